// File: rtl/alu_seq_01.sv
// Accumulator sequencer: fetches 8-bit instructions over a req/ack memory port and
// executes them against an external combinational ALU.
module alu_seq_01 #(
  parameter int BUS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  halted,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_ack,
  output logic [1:0]            alu_op,
  output logic [BUS_WIDTH-1:0]  alu_a,
  output logic [BUS_WIDTH-1:0]  alu_b,
  input  logic [BUS_WIDTH-1:0]  alu_y,
  output logic [BUS_WIDTH-1:0]  acc
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC, S_WRITE, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_HALT  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_STORE = 3'b010,
    OP_ADD   = 3'b011,
    OP_SUB   = 3'b100,
    OP_AND   = 3'b101,
    OP_JMP   = 3'b110,
    OP_JZ    = 3'b111
  } opcode_e;

  localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(START_ADDR);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [BUS_WIDTH-1:0]  ir_q, ir_d;
  logic [BUS_WIDTH-1:0]  acc_q, acc_d;
  logic [BUS_WIDTH-1:0]  opnd_q, opnd_d;

  opcode_e               opcode;
  logic [ADDR_WIDTH-1:0] ir_addr;

  assign opcode  = opcode_e'(ir_q[BUS_WIDTH-1 -: 3]);
  assign ir_addr = ir_q[ADDR_WIDTH-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      ir_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    alu_op    = 2'b00;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = START_PC;
          acc_d   = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_HALT:  state_d = S_HALT;
          OP_JMP: begin
            pc_d    = ir_addr;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (acc_q == '0) pc_d = ir_addr;
            state_d = S_FETCH;
          end
          OP_STORE: state_d = S_WRITE;
          default:  state_d = S_READ;
        endcase
      end

      // Operand fetch: LOAD retires here, ALU ops continue to EXEC.
      S_READ: begin
        mem_req  = 1'b1;
        mem_addr = ir_addr;
        if (mem_ack) begin
          if (opcode == OP_LOAD) begin
            acc_d   = mem_rdata;
            state_d = S_FETCH;
          end else begin
            opnd_d  = mem_rdata;
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        case (opcode)
          OP_SUB:  alu_op = 2'b01;
          OP_AND:  alu_op = 2'b10;
          default: alu_op = 2'b00;
        endcase
        acc_d   = alu_y;
        state_d = S_FETCH;
      end

      S_WRITE: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = ir_addr;
        mem_wdata = acc_q;
        if (mem_ack) state_d = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);
  assign alu_a  = acc_q;
  assign alu_b  = opnd_q;
  assign acc    = acc_q;

endmodule

// File: tb/tb_alu_seq_01.sv
// Directed bench for alu_seq_01: 32-word memory model with programmable ack delay
// and a combinational ALU model.
module tb_alu_seq_01;

  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic       busy, halted;
  logic       mem_req, mem_wr, mem_ack;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y, acc;

  logic [7:0] mem [32];
  int         wait_cycles = 0;
  int         wcnt = 0;
  logic       tb_we = 1'b0;
  logic [4:0] tb_waddr = '0;
  logic [7:0] tb_wdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq_01 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .halted    (halted),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (wcnt == wait_cycles);
  assign mem_rdata = (mem_req && !mem_wr) ? mem[mem_addr] : 8'h00;
  assign alu_y     = (alu_op == 2'b01) ? alu_a - alu_b :
                     (alu_op == 2'b10) ? alu_a & alu_b : alu_a + alu_b;

  always @(posedge clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    else if (mem_req && mem_wr && mem_ack) mem[mem_addr] <= mem_wdata;
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    tb_we    = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    step();
    tb_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs until HALT, counting edges and checking request stability across waits.
  task automatic run_to_halt(input string tag, output int cycles);
    int         stab_err;
    logic       p_req, p_ack, p_wr;
    logic [4:0] p_addr;
    logic [7:0] p_wd;
    cycles   = 0;
    stab_err = 0;
    p_req = mem_req; p_ack = mem_ack; p_wr = mem_wr; p_addr = mem_addr; p_wd = mem_wdata;
    while (!halted && cycles < 500) begin
      step();
      cycles++;
      if (p_req && !p_ack &&
          (mem_req !== 1'b1 || mem_wr !== p_wr || mem_addr !== p_addr || mem_wdata !== p_wd))
        stab_err++;
      p_req = mem_req; p_ack = mem_ack; p_wr = mem_wr; p_addr = mem_addr; p_wd = mem_wdata;
    end
    check({tag, "_req_stable"}, stab_err, 0);
    check({tag, "_halt_reached"}, halted, 1'b1);
  endtask

  initial begin
    int n;
    bit seen;

    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_addr", mem_addr, 5'd0);
    check("rst_mem_wdata", mem_wdata, 8'd0);
    check("rst_alu_op", alu_op, 2'b00);
    check("rst_alu_ab", {alu_a, alu_b}, 16'h0000);
    check("rst_acc", acc, 8'd0);

    for (int i = 0; i < 32; i++) poke(5'(i), 8'h00);
    rst = 1'b1;
    repeat (3) step();
    check("idle_no_start", busy, 1'b0);

    // Basic program, zero wait: LOAD 10, ADD 11, STORE 12, HALT
    poke(5'd0, 8'h2A); poke(5'd1, 8'h6B); poke(5'd2, 8'h4C); poke(5'd3, 8'h00);
    poke(5'd10, 8'd5); poke(5'd11, 8'd3);
    wait_cycles = 0;
    pulse_start();
    check("basic_busy", busy, 1'b1);
    check("basic_first_fetch", {mem_req, mem_wr, mem_addr}, {1'b1, 1'b0, 5'd0});
    run_to_halt("basic", n);
    check("basic_cycles", n, 12);
    check("basic_acc", acc, 8'd8);
    check("basic_mem12", mem[12], 8'd8);
    check("basic_not_busy", busy, 1'b0);

    // Same program with 3 wait cycles on every transfer: 7 transfers x 3 extra
    poke(5'd12, 8'h00);
    wait_cycles = 3;
    pulse_start();
    run_to_halt("wait", n);
    check("wait_cycles", n, 33);
    check("wait_acc", acc, 8'd8);
    check("wait_mem12", mem[12], 8'd8);

    // Start pulse during EXEC of the ADD must be ignored
    poke(5'd12, 8'h00);
    wait_cycles = 0;
    pulse_start();
    repeat (6) step();
    check("exec_alu_op_add", alu_op, 2'b00);
    check("exec_alu_ab", {alu_a, alu_b}, {8'd5, 8'd3});
    check("exec_busy", busy, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("post_exec_fetch", {mem_req, mem_wr, mem_addr, alu_op}, {1'b1, 1'b0, 5'd2, 2'b00});
    check("post_exec_acc", acc, 8'd8);
    run_to_halt("busy_start", n);
    check("busy_start_cycles", n + 7, 12);
    check("busy_start_mem12", mem[12], 8'd8);

    // JZ taken with ACC=0
    poke(5'd0, 8'hF4); poke(5'd20, 8'h00);
    pulse_start();
    repeat (2) step();
    check("jz_taken_addr", {mem_req, mem_addr}, {1'b1, 5'd20});
    run_to_halt("jz_taken", n);
    check("jz_taken_acc", acc, 8'd0);

    // JZ not taken with ACC=1
    poke(5'd0, 8'h3E); poke(5'd30, 8'h01); poke(5'd1, 8'hF4); poke(5'd2, 8'h00);
    pulse_start();
    repeat (5) step();
    check("jz_not_taken_addr", {mem_req, mem_addr}, {1'b1, 5'd2});
    run_to_halt("jz_not_taken", n);
    check("jz_not_taken_acc", acc, 8'd1);

    // SUB 7-9 via JMP 29 .. sequential to 31, JMP 5, STORE 26, HALT
    poke(5'd24, 8'd7); poke(5'd25, 8'd9); poke(5'd26, 8'h00);
    poke(5'd0, 8'hDD); poke(5'd29, 8'h38); poke(5'd30, 8'h99); poke(5'd31, 8'hC5);
    poke(5'd5, 8'h5A); poke(5'd6, 8'h00);
    pulse_start();
    run_to_halt("sub", n);
    check("sub_cycles", n, 16);
    check("sub_acc", acc, 8'hFE);
    check("sub_mem26", mem[26], 8'hFE);

    // PC wrap: JZ not taken at address 31 must fetch address 0 next
    poke(5'd0, 8'hDE); poke(5'd30, 8'h38); poke(5'd31, 8'hF4);
    pulse_start();
    repeat (7) step();
    check("pc_wrap_addr", {mem_req, mem_wr, mem_addr}, {1'b1, 1'b0, 5'd0});
    check("pc_wrap_acc", acc, 8'd7);
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Reset in the middle of a waited WRITE
    poke(5'd0, 8'h38); poke(5'd1, 8'h5B); poke(5'd2, 8'h00); poke(5'd27, 8'h55);
    wait_cycles = 3;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (mem_req && mem_wr) seen = 1'b1;
      else step();
    end
    check("write_reached", seen, 1'b1);
    check("write_wdata", mem_wdata, 8'd7);
    #2 rst = 1'b0;
    #1;
    check("rst_write_req", {mem_req, mem_wr}, 2'b00);
    check("rst_write_busy", busy, 1'b0);
    check("rst_write_acc", acc, 8'd0);
    check("rst_write_wdata", mem_wdata, 8'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_write_target", mem[27], 8'h55);
    repeat (3) step();
    check("post_rst_idle", {busy, halted, mem_req}, 3'b000);
    check("post_rst_target", mem[27], 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
